// File: rtl/spart_cmd_tx_pkg.sv
// Shared SPART link definitions: baud codes, divisor helper, command codes.
// Used by both the command transmitter and the SPART receiver.
package spart_cmd_tx_pkg;

    localparam logic [1:0] BR_4800  = 2'b00;
    localparam logic [1:0] BR_9600  = 2'b01;
    localparam logic [1:0] BR_19200 = 2'b10;
    localparam logic [1:0] BR_38400 = 2'b11;

    localparam logic [7:0] CMD_START_PROG = 8'h73;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    function automatic int unsigned baud_rate(input logic [1:0] br);
        int unsigned r;
        case (br)
            BR_4800:  r = 4800;
            BR_9600:  r = 9600;
            BR_19200: r = 19200;
            default:  r = 38400;
        endcase
        return r;
    endfunction

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input logic [1:0]  br);
        int unsigned b;
        b = baud_rate(br);
        return (clk_hz + b / 2) / b;
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Loadable baud down-counter: bit_tick marks the last clock of each bit.
// The reload value is held so every bit lasts exactly rld+1 clocks.
module spart_baud_gen #(
    parameter int unsigned CW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] rld,
    output logic          bit_tick
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] rld_q;

    assign bit_tick = en && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rld_q <= '0;
        end else if (load) begin
            cnt_q <= rld;
            rld_q <= rld;
        end else if (bit_tick) begin
            cnt_q <= rld_q;
        end else if (en) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/spart_cmd_tx.sv
// Host-side SPART command sender: cmd byte then payload bytes (MS first),
// framed 8N1 on txd at a br_cfg-selected baud rate.
module spart_cmd_tx
    import spart_cmd_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned PAYLOAD_BYTES = 8,
    parameter int unsigned SIM_DIV       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 cmd,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    input  logic [1:0]                 br_cfg,
    output logic                       txd,
    output logic                       busy,
    output logic                       done,
    output logic [3:0]                 byte_idx
);

    localparam int unsigned PW = 8 * PAYLOAD_BYTES;

    localparam int unsigned D0 = (SIM_DIV != 0) ? SIM_DIV : baud_div(CLK_HZ, BR_4800);
    localparam int unsigned D1 = (SIM_DIV != 0) ? SIM_DIV : baud_div(CLK_HZ, BR_9600);
    localparam int unsigned D2 = (SIM_DIV != 0) ? SIM_DIV : baud_div(CLK_HZ, BR_19200);
    localparam int unsigned D3 = (SIM_DIV != 0) ? SIM_DIV : baud_div(CLK_HZ, BR_38400);

    // 4800 baud has the largest divisor, so it sizes the counter.
    localparam int unsigned CW = $clog2(D0 + 1);

    localparam logic [CW-1:0] R0 = CW'(D0 - 1);
    localparam logic [CW-1:0] R1 = CW'(D1 - 1);
    localparam logic [CW-1:0] R2 = CW'(D2 - 1);
    localparam logic [CW-1:0] R3 = CW'(D3 - 1);

    localparam logic [3:0] LAST = 4'(PAYLOAD_BYTES);

    tx_state_e      state_q, state_d;
    logic           txd_q, txd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [3:0]     idx_q, idx_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     sh_q, sh_d;
    logic [PW-1:0]  pay_q, pay_d;

    logic           accept;
    logic           tick;
    logic [CW-1:0]  rld_sel;

    assign accept = (state_q == ST_IDLE) && start;

    always_comb begin
        rld_sel = R3;
        unique case (br_cfg)
            BR_4800:  rld_sel = R0;
            BR_9600:  rld_sel = R1;
            BR_19200: rld_sel = R2;
            BR_38400: rld_sel = R3;
        endcase
    end

    spart_baud_gen #(
        .CW (CW)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .en       (state_q != ST_IDLE),
        .rld      (rld_sel),
        .bit_tick (tick)
    );

    always_comb begin
        state_d = state_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pay_d   = pay_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = 4'd0;
                    bit_d   = 3'd0;
                    sh_d    = cmd;
                    pay_d   = payload;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    txd_d   = sh_q[0];
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (idx_q == LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Next byte follows with no idle gap.
                        state_d = ST_START;
                        txd_d   = 1'b0;
                        idx_d   = idx_q + 4'd1;
                        sh_d    = pay_q[PW-1 -: 8];
                        pay_d   = pay_q << 8;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 4'd0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            pay_q   <= pay_d;
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign byte_idx = idx_q;

endmodule
